// File: rtl/avalon_st_pkg.sv
// Shared helpers for the Avalon-ST width adapters: width arithmetic,
// parameter sanity checks and the sub-beat sequencer state type.
package avalon_st_pkg;

    // Sub-beat sequencer state: IDLE means the hold register is empty.
    typedef enum logic {
        SUB_IDLE = 1'b0,
        SUB_EMIT = 1'b1
    } sub_state_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Width of an empty / index field, never narrower than one bit.
    function automatic int empty_w(input int symbols);
        return (clog2(symbols) < 1) ? 1 : clog2(symbols);
    endfunction

    // Number of narrow beats per wide beat.
    function automatic int ratio(input int in_symbols, input int out_symbols);
        return in_symbols / ((out_symbols < 1) ? 1 : out_symbols);
    endfunction

    // Legal narrower configuration: output divides input evenly.
    function automatic bit narrow_params_ok(input int in_symbols, input int out_symbols);
        return (out_symbols >= 1) && (out_symbols <= in_symbols) &&
               ((in_symbols % out_symbols) == 0);
    endfunction

endpackage

// File: rtl/avalon_st_out_stage.sv
// Generic ready/valid output register. Accepts a new payload whenever the
// register is empty or being drained, and holds its contents on stall.
module avalon_st_out_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    assign in_ready = out_ready || !out_valid;

    // Load on free slot, hold while the consumer stalls.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
        end
    end

endmodule

// File: rtl/avalon_st_width_narrower.sv
// Avalon-ST symbol-width narrower: each IN_SYMBOLS-wide beat leaves as up to
// RATIO OUT_SYMBOLS-wide beats, MSB symbol first, with the EOP beat trimmed by
// its empty count so padding symbols are never emitted.
module avalon_st_width_narrower
    import avalon_st_pkg::*;
#(
    parameter int SYMBOL_W    = 8,
    parameter int IN_SYMBOLS  = 3,
    parameter int OUT_SYMBOLS = 1,
    parameter int CHANNEL_W   = 1,
    parameter int ERROR_W     = 1,
    localparam int RATIO       = ratio(IN_SYMBOLS, OUT_SYMBOLS),
    localparam int IN_EMPTY_W  = empty_w(IN_SYMBOLS),
    localparam int OUT_EMPTY_W = empty_w(OUT_SYMBOLS)
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic                            in_ready,
    input  logic                            in_valid,
    input  logic [IN_SYMBOLS*SYMBOL_W-1:0]  in_data,
    input  logic                            in_startofpacket,
    input  logic                            in_endofpacket,
    input  logic [IN_EMPTY_W-1:0]           in_empty,
    input  logic [CHANNEL_W-1:0]            in_channel,
    input  logic [ERROR_W-1:0]              in_error,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [OUT_SYMBOLS*SYMBOL_W-1:0] out_data,
    output logic                            out_startofpacket,
    output logic                            out_endofpacket,
    output logic [OUT_EMPTY_W-1:0]          out_empty,
    output logic [CHANNEL_W-1:0]            out_channel,
    output logic [ERROR_W-1:0]              out_error
);

    localparam int IN_W      = IN_SYMBOLS * SYMBOL_W;
    localparam int OUT_W     = OUT_SYMBOLS * SYMBOL_W;
    localparam int IDX_W     = empty_w(RATIO);
    localparam int PAYLOAD_W = OUT_W + 2 + OUT_EMPTY_W + CHANNEL_W + ERROR_W;

    if (!narrow_params_ok(IN_SYMBOLS, OUT_SYMBOLS)) begin : g_bad_params
        $error("IN_SYMBOLS must be a non-zero multiple of OUT_SYMBOLS");
    end

    // Hold register A and the sub-beat sequencer.
    sub_state_t              state;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        a_last;
    logic [OUT_EMPTY_W-1:0]  a_pad;
    logic [IN_W-1:0]         a_data;
    logic                    a_sop;
    logic                    a_eop;
    logic [CHANNEL_W-1:0]    a_channel;
    logic [ERROR_W-1:0]      a_error;

    logic                    a_valid;
    logic                    load;
    logic                    last_sub;
    logic                    accept;
    logic                    is_eop_sub;
    logic [OUT_W-1:0]        sel_data;
    logic [IDX_W-1:0]        cap_last;
    logic [OUT_EMPTY_W-1:0]  cap_pad;
    logic [PAYLOAD_W-1:0]    stage_in;
    logic [PAYLOAD_W-1:0]    stage_out;
    int                      eff_empty;
    int                      n_valid;
    int                      n_beats;

    assign a_valid  = (state == SUB_EMIT);
    assign last_sub = (idx == a_last);
    assign in_ready = !reset && (!a_valid || (load && last_sub));
    assign accept   = in_valid && in_ready;

    // Precompute the last sub-beat index and EOP padding of the incoming beat.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        eff_empty = 0;
        if (in_endofpacket) begin
            eff_empty = (int'(in_empty) >= IN_SYMBOLS) ? IN_SYMBOLS - 1 : int'(in_empty);
        end
        n_valid  = IN_SYMBOLS - eff_empty;
        n_beats  = (n_valid + OUT_SYMBOLS - 1) / OUT_SYMBOLS;
        cap_last = IDX_W'(n_beats - 1);
        cap_pad  = OUT_EMPTY_W'(n_beats * OUT_SYMBOLS - n_valid);
    end

    // Sequencer: capture a beat, step idx per drained sub-beat, release at last_sub.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SUB_IDLE;
            idx       <= '0;
            a_last    <= '0;
            a_pad     <= '0;
            a_data    <= '0;
            a_sop     <= 1'b0;
            a_eop     <= 1'b0;
            a_channel <= '0;
            a_error   <= '0;
        end else if (accept) begin
            state     <= SUB_EMIT;
            idx       <= '0;
            a_last    <= cap_last;
            a_pad     <= cap_pad;
            a_data    <= in_data;
            a_sop     <= in_startofpacket;
            a_eop     <= in_endofpacket;
            a_channel <= in_channel;
            a_error   <= in_error;
        end else if (a_valid && load) begin
            if (last_sub) begin
                state <= SUB_IDLE;
                idx   <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Pick the current sub-beat symbols (MSB first) and its framing flags.
    always_comb begin
        sel_data   = a_data[IN_W - 1 - int'(idx) * OUT_W -: OUT_W];
        is_eop_sub = a_eop && last_sub;
        stage_in   = {sel_data,
                      a_sop && (idx == '0),
                      is_eop_sub,
                      is_eop_sub ? a_pad : OUT_EMPTY_W'(0),
                      a_channel,
                      a_error};
    end

    avalon_st_out_stage #(
        .WIDTH(PAYLOAD_W)
    ) u_out_stage (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (a_valid),
        .in_ready  (load),
        .in_data   (stage_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (stage_out)
    );

    assign {out_data, out_startofpacket, out_endofpacket, out_empty, out_channel, out_error} = stage_out;

endmodule

// File: tb/tb_avalon_st_width_narrower.sv
// Self-checking bench: default 24->8 narrower driven through a scoreboard
// (table vectors, random backpressure, mid-packet reset, back-to-back), plus
// a 32->16 instance for the multi-symbol output case.
module tb_avalon_st_width_narrower;

    // ---------------- default instance (IN=3, OUT=1) ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        in_ready, in_valid;
    logic [23:0] in_data;
    logic        in_startofpacket, in_endofpacket;
    logic [1:0]  in_empty;
    logic        in_channel, in_error;
    logic        out_ready, out_valid;
    logic [7:0]  out_data;
    logic        out_startofpacket, out_endofpacket;
    logic        out_empty, out_channel, out_error;

    always #5 clk = ~clk;

    avalon_st_width_narrower dut (
        .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid),
        .in_data(in_data), .in_startofpacket(in_startofpacket),
        .in_endofpacket(in_endofpacket), .in_empty(in_empty),
        .in_channel(in_channel), .in_error(in_error), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
        .out_empty(out_empty), .out_channel(out_channel), .out_error(out_error)
    );

    // ---------------- second instance (IN=4, OUT=2) ----------------
    logic        b_in_ready, b_in_valid;
    logic [31:0] b_in_data;
    logic        b_in_sop, b_in_eop;
    logic [1:0]  b_in_empty;
    logic        b_in_channel, b_in_error;
    logic        b_out_ready, b_out_valid;
    logic [15:0] b_out_data;
    logic        b_out_sop, b_out_eop, b_out_empty, b_out_channel, b_out_error;

    avalon_st_width_narrower #(
        .SYMBOL_W(8), .IN_SYMBOLS(4), .OUT_SYMBOLS(2), .CHANNEL_W(1), .ERROR_W(1)
    ) dut2 (
        .clk(clk), .reset(reset), .in_ready(b_in_ready), .in_valid(b_in_valid),
        .in_data(b_in_data), .in_startofpacket(b_in_sop),
        .in_endofpacket(b_in_eop), .in_empty(b_in_empty),
        .in_channel(b_in_channel), .in_error(b_in_error), .out_ready(b_out_ready),
        .out_valid(b_out_valid), .out_data(b_out_data),
        .out_startofpacket(b_out_sop), .out_endofpacket(b_out_eop),
        .out_empty(b_out_empty), .out_channel(b_out_channel), .out_error(b_out_error)
    );

    // ---------------- bookkeeping ----------------
    typedef struct {
        logic [23:0] data;
        logic        sop, eop;
        logic [1:0]  empty;
        logic        ch, err;
        int          n;          // expected number of output beats
        logic [23:0] exp_syms;   // expected symbols, left aligned
    } vec_t;

    int          checks = 0;
    int          fails  = 0;
    vec_t        src_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] b_got[$];
    int          acc_q[$];
    int          bp_pct = 0, gap_pct = 0;
    int          cyc = 0, out_count = 0, out_first = 0, out_last = 0;
    logic        accepted = 1'b0, stalled = 1'b0;
    logic [31:0] held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] out_pack();
        return 32'({out_valid, out_data, out_startofpacket, out_endofpacket,
                    out_empty, out_channel, out_error});
    endfunction

    function automatic logic [31:0] b_pack(input logic [15:0] d, input logic s, input logic e,
                                           input logic em, input logic c, input logic r);
        return 32'({d, s, e, em, c, r});
    endfunction

    function automatic vec_t mk(input logic [23:0] d, input logic s, input logic e,
                                input logic [1:0] em, input logic c, input logic r,
                                input int n, input logic [23:0] x);
        vec_t v;
        v.data = d; v.sop = s; v.eop = e; v.empty = em; v.ch = c; v.err = r;
        v.n = n; v.exp_syms = x;
        return v;
    endfunction

    // Reference model: keep the leading symbols that the empty count leaves valid.
    function automatic vec_t with_expect(input vec_t v);
        int eff;
        eff = 0;
        if (v.eop) eff = (v.empty > 2'd2) ? 2 : int'(v.empty);
        v.n        = 3 - eff;
        v.exp_syms = v.data & (24'hFFFFFF << (8 * eff));
        return v;
    endfunction

    task automatic push_expect(input vec_t v);
        logic [23:0] t;
        for (int i = 0; i < v.n; i++) begin
            t = v.exp_syms << (8 * i);
            exp_q.push_back(32'({1'b1, t[23:16], v.sop && (i == 0),
                                 v.eop && (i == v.n - 1), 1'b0, v.ch, v.err}));
        end
    endtask

    // One clock of the default instance: drive at negedge, evaluate 1 unit later.
    task automatic step();
        @(negedge clk);
        if (accepted) begin
            in_valid = 1'b0;
            accepted = 1'b0;
        end
        out_ready = ($urandom_range(99) >= bp_pct);
        if (!in_valid && src_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            in_valid         = 1'b1;
            in_data          = src_q[0].data;
            in_startofpacket = src_q[0].sop;
            in_endofpacket   = src_q[0].eop;
            in_empty         = src_q[0].empty;
            in_channel       = src_q[0].ch;
            in_error         = src_q[0].err;
        end
        #1;
        if (stalled) check("stall_hold", out_pack(), held);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(out_valid), 0);
            end else begin
                check("out_beat", out_pack(), exp_q.pop_front());
            end
            if (out_count == 0) out_first = cyc;
            out_last = cyc;
            out_count++;
        end
        stalled = out_valid && !out_ready;
        held    = out_pack();
        if (in_valid && in_ready) begin
            push_expect(src_q.pop_front());
            acc_q.push_back(cyc);
            accepted = 1'b1;
        end
        cyc++;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (src_q.size() > 0 || exp_q.size() > 0); i++) step();
        check("drain_src_left", 32'(src_q.size()), 0);
        check("drain_exp_left", 32'(exp_q.size()), 0);
    endtask

    task automatic b_send(input logic [31:0] d, input logic s, input logic e, input logic [1:0] em);
        @(negedge clk);
        b_in_valid = 1'b1; b_in_data = d; b_in_sop = s; b_in_eop = e; b_in_empty = em;
        #1;
        for (int i = 0; i < 20 && !b_in_ready; i++) begin
            @(negedge clk);
            #1;
        end
        check("b_accept", 32'(b_in_ready), 1);
        @(posedge clk);
        #1 b_in_valid = 1'b0;
    endtask

    // Capture every transfer of the second instance.
    always @(negedge clk) begin
        #2;
        if (b_out_valid && b_out_ready)
            b_got.push_back(b_pack(b_out_data, b_out_sop, b_out_eop, b_out_empty,
                                   b_out_channel, b_out_error));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        vec_t        v;
        logic [31:0] b_exp[6];
        int          len;
        logic        pch;

        // Directed vectors: {inputs, expected beat count, expected symbols}.
        tbl[0] = mk(24'hAABBCC, 1, 0, 2'd0, 0, 0, 3, 24'hAABBCC);
        tbl[1] = mk(24'h112233, 0, 1, 2'd0, 0, 0, 3, 24'h112233);
        tbl[2] = mk(24'hDDEEFF, 1, 1, 2'd2, 0, 1, 1, 24'hDD0000);
        tbl[3] = mk(24'h123456, 1, 0, 2'd3, 1, 0, 3, 24'h123456);
        tbl[4] = mk(24'h789ABC, 0, 1, 2'd3, 1, 1, 1, 24'h780000);
        tbl[5] = mk(24'h0F1E2D, 1, 1, 2'd1, 0, 0, 2, 24'h0F1E00);

        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
        in_empty = '0; in_channel = 1'b0; in_error = 1'b0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_sop = 1'b0; b_in_eop = 1'b0;
        b_in_empty = '0; b_in_channel = 1'b1; b_in_error = 1'b0; b_out_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 0);
        check("reset_outputs", out_pack(), 0);
        check("reset_b_in_ready", 32'(b_in_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("in_ready_after_reset", 32'(in_ready), 1);

        // Table vectors, no backpressure.
        bp_pct = 0; gap_pct = 0;
        for (int i = 0; i < 6; i++) src_q.push_back(tbl[i]);
        drain(200);

        // 32->16 instance: trimming with output empty.
        b_send(32'h01020304, 1, 1, 2'd1);
        b_send(32'h0A0B0C0D, 1, 1, 2'd3);
        b_send(32'h11223344, 1, 0, 2'd3);
        b_send(32'h55667788, 0, 1, 2'd2);
        repeat (8) @(negedge clk);
        b_exp[0] = b_pack(16'h0102, 1, 0, 0, 1, 0);
        b_exp[1] = b_pack(16'h0304, 0, 1, 1, 1, 0);
        b_exp[2] = b_pack(16'h0A0B, 1, 1, 1, 1, 0);
        b_exp[3] = b_pack(16'h1122, 1, 0, 0, 1, 0);
        b_exp[4] = b_pack(16'h3344, 0, 0, 0, 1, 0);
        b_exp[5] = b_pack(16'h5566, 0, 1, 0, 1, 0);
        check("b_beat_count", 32'(b_got.size()), 6);
        for (int i = 0; i < 6 && i < b_got.size(); i++) check("b_beat", b_got[i], b_exp[i]);

        // Random packets under 50% backpressure and input gaps.
        bp_pct = 50; gap_pct = 30;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(1, 3);
            pch = 1'($urandom_range(0, 1));
            for (int b = 0; b < len; b++) begin
                v.data  = 24'($urandom());
                v.sop   = (b == 0);
                v.eop   = (b == len - 1);
                v.empty = 2'($urandom_range(0, 3));
                v.ch    = pch;
                v.err   = 1'($urandom_range(0, 1));
                src_q.push_back(with_expect(v));
            end
        end
        drain(5000);

        // Reset after two of three sub-beats; next packet must restart cleanly.
        bp_pct = 0; gap_pct = 0; out_count = 0;
        src_q.push_back(mk(24'hA1B2C3, 1, 0, 2'd0, 1, 1, 3, 24'hA1B2C3));
        for (int i = 0; i < 20 && out_count < 2; i++) step();
        check("mid_reset_reached", 32'(out_count), 2);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; accepted = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset_outputs", out_pack(), 0);
        check("mid_reset_in_ready", 32'(in_ready), 0);
        exp_q.delete();
        stalled = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        src_q.push_back(mk(24'h445566, 1, 1, 2'd0, 0, 0, 3, 24'h445566));
        drain(100);

        // Back-to-back input, downstream always ready.
        out_count = 0; acc_q.delete();
        for (int b = 0; b < 6; b++) begin
            v.data = 24'($urandom()); v.sop = (b == 0); v.eop = (b == 5);
            v.empty = 2'd0; v.ch = 1'b0; v.err = 1'b0;
            src_q.push_back(with_expect(v));
        end
        drain(100);
        check("b2b_out_count", 32'(out_count), 18);
        check("b2b_out_continuous", 32'(out_last - out_first + 1), 32'(out_count));
        check("b2b_accept_count", 32'(acc_q.size()), 6);
        for (int i = 1; i < acc_q.size(); i++)
            check("b2b_accept_spacing", 32'(acc_q[i] - acc_q[i-1]), 3);

        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
